// File: rtl/rca_pkg.sv
// rca_pkg: shared defaults and the pipeline stage record for pipelined_rca.
//  DEF_WIDTH / DEF_CHUNK : default operand width and bits resolved per stage
//  stage_t               : one pipeline stage at the default width
//                          (valid, sub flag, carry, carry into MSB, partial sum, pending a/b)
package rca_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic                 carry;
        logic                 c_msb;
        logic [DEF_WIDTH-1:0] s;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } stage_t;
endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry slice built from one-bit full adders.
//  a, b     in  CHUNK  slice operands
//  ci       in  1      carry into bit 0
//  s        out CHUNK  slice sum
//  co       out 1      carry out of the top bit
//  c_msb_in out 1      carry into the top bit (signed-overflow detection)
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar j = 0; j < CHUNK; j++) begin : g_fa
        assign s[j]   = a[j] ^ b[j] ^ c[j];
        assign c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage.
//  clk, rst_n          clock, asynchronous active-low reset
//  in_valid/in_ready   input handshake; a, b, cin, sub operands and mode
//  out_valid/out_ready output handshake; sum, cout, ovf result
//  {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin); ovf = carry into MSB ^ carry out of MSB.
//  Latency WIDTH/CHUNK cycles, one operation per clock.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0 || WIDTH < CHUNK) begin : g_chk
        $error("pipelined_rca: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic             c_msb;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stg_t;

    stg_t              stg_q [STAGES];
    stg_t              stg_d [STAGES];
    stg_t              entry;
    logic [STAGES:0]   rdy;

    // Subtraction is folded in here: b inverted and carry-in forced high once, at entry.
    assign entry = '{valid: in_valid, sub: sub, carry: sub | cin, c_msb: 1'b0,
                     s: '0, a: a, b: sub ? ~b : b};

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        stg_t             up;
        stg_t             nxt;
        logic [CHUNK-1:0] cs;
        logic             co;
        logic             cm;

        assign up     = (i == 0) ? entry : stg_q[(i == 0) ? 0 : i-1];
        assign rdy[i] = !stg_q[i].valid || rdy[i+1];

        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (up.a[i*CHUNK +: CHUNK]),
            .b        (up.b[i*CHUNK +: CHUNK]),
            .ci       (up.carry),
            .s        (cs),
            .co       (co),
            .c_msb_in (cm)
        );

        always_comb begin
            nxt                      = up;
            nxt.s[i*CHUNK +: CHUNK]  = cs;
            nxt.carry                = co;
            nxt.c_msb                = (i == STAGES-1) ? cm : up.c_msb;
        end

        // A stage loads whenever it can pass its contents on; otherwise it holds.
        assign stg_d[i] = rdy[i] ? nxt : stg_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign out_valid = stg_q[STAGES-1].valid;
    assign sum       = stg_q[STAGES-1].s;
    assign cout      = stg_q[STAGES-1].carry;
    assign ovf       = stg_q[STAGES-1].c_msb ^ stg_q[STAGES-1].carry;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: self-checking bench for pipelined_rca (WIDTH=16, CHUNK=4).
module tb_pipelined_rca;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_emit = 0;
    logic acc;
    logic [17:0] sb[$];

    pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        int ux = x;
        int uy = y;
        int sx = $signed(x);
        int sy = $signed(y);
        int ru;
        int rs;
        logic co;
        if (s) begin
            ru = ux - uy;
            rs = sx - sy;
            co = (ux >= uy);
        end else begin
            ru = ux + uy + int'(c);
            rs = sx + sy + int'(c);
            co = (ru > 65535);
        end
        return {(rs > 32767 || rs < -32768), co, ru[15:0]};
    endfunction

    task automatic new_op();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // One clock: inputs already driven; observe handshakes mid-cycle, score them.
    task automatic cycle();
        logic [17:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_cmp++;
            n_emit++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: got %h, required no result", {ovf, cout, sum});
            end else begin
                e = sb.pop_front();
                if ({ovf, cout, sum} !== e) begin
                    n_bad++;
                    $display("FAIL out_data: got {ovf,cout,sum}=%h, required %h", {ovf, cout, sum}, e);
                end
            end
        end
        if (acc) sb.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        n_cmp++; if (sum !== 16'h0) begin n_bad++; $display("FAIL rst_sum: got %h, required 0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b, required 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b, required 0", ovf); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int lat;
        a = ta; b = tb_; cin = tc; sub = ts;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %b, required 1", nm, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL %s_latency: got %0d, required 4", nm, lat); end
        n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL %s_sum: got %h, required %h", nm, sum, es); end
        n_cmp++; if (cout !== ec) begin n_bad++; $display("FAIL %s_cout: got %b, required %b", nm, cout, ec); end
        n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL %s_ovf: got %b, required %b", nm, ovf, eo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_cin_ign");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, "add_cin");
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int accepts = 0;
        int e0;
        sb.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        new_op();
        repeat (8) begin
            cycle();
            if (acc) begin accepts++; sent++; new_op(); end
        end
        n_cmp++; if (accepts != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d, required 4", accepts); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        out_ready = 1'b1;
        e0 = n_emit;
        repeat (10) begin
            in_valid = (sent < 10);
            cycle();
            if (acc) begin sent++; new_op(); end
        end
        in_valid = 1'b0;
        n_cmp++; if (n_emit - e0 != 10) begin n_bad++; $display("FAIL bp_emits: got %0d in 10 cycles, required 10", n_emit - e0); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL bp_left: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        int e0;
        sb.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        new_op();
        repeat (3) begin
            cycle();
            new_op();
        end
        in_valid = 1'b0;
        cycle();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_loaded: got out_valid=%b, required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        e0 = n_emit;
        repeat (6) cycle();
        n_cmp++; if (n_emit != e0) begin n_bad++; $display("FAIL mid_stale: got %0d results, required 0", n_emit - e0); end
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "mid_after");
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        sb.delete();
        new_op();
        while (sent < 10000 && cyc < 50000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            cycle();
            cyc++;
            if (acc) begin sent++; new_op(); end
        end
        n_cmp++; if (sent != 10000) begin n_bad++; $display("FAIL rnd_budget: got %0d sent, required 10000", sent); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            cycle();
            cyc++;
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d pending, required 0", sb.size()); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_idle: got out_valid=%b, required 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
